// File: rtl/pmod_debounce.sv
// Per-bit synchroniser plus stability-counter debouncer for raw PMOD pins.
// Define PMOD_DEBOUNCE_EDGE_EN to build the registered rise/fall strobes.
module pmod_debounce #(
    parameter int WIDTH         = 2,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 12000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] pmod,
    output logic [WIDTH-1:0] pmod_db,
    output logic [WIDTH-1:0] pmod_rise,
    output logic [WIDTH-1:0] pmod_fall
);

    localparam int CNT_W = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic {
        IDLE,
        PENDING
    } state_e;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic [SYNC_STAGES-1:0] sync_q;
        logic [CNT_W-1:0]       cnt_q;
        logic [CNT_W-1:0]       cnt_d;
        logic                   db_q;
        logic                   db_d;
        logic                   s;
        logic                   accept;
        state_e                 state;

        assign s = sync_q[SYNC_STAGES-1];

        // sync_q[0] is the only flop that samples the asynchronous pin.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_q <= '0;
                cnt_q  <= '0;
                db_q   <= 1'b0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], pmod[i]};
                cnt_q  <= cnt_d;
                db_q   <= db_d;
            end
        end

        always_comb begin
            state  = (s != db_q) ? PENDING : IDLE;
            cnt_d  = '0;
            accept = 1'b0;
            case (state)
                IDLE: cnt_d = '0;
                PENDING: begin
                    if (cnt_q == CNT_MAX) begin
                        accept = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: cnt_d = '0;
            endcase
        end

        assign db_d       = accept ? s : db_q;
        assign pmod_db[i] = db_q;

`ifdef PMOD_DEBOUNCE_EDGE_EN
        logic rise_q;
        logic fall_q;

        // Strobes fire in the cycle after the accepting edge, alongside the new level.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                rise_q <= accept & s;
                fall_q <= accept & ~s;
            end
        end

        assign pmod_rise[i] = rise_q;
        assign pmod_fall[i] = fall_q;
`else
        assign pmod_rise[i] = 1'b0;
        assign pmod_fall[i] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_pmod_debounce.sv
// Bench for pmod_debounce: window-based reference model checked every cycle,
// plus literal timing checks for reset, step, glitch, bounce and mid-count reset.
module tb_pmod_debounce;

    localparam int WIDTH  = 2;
    localparam int SYNC   = 2;
    localparam int STABLE = 4;
    localparam int DEPTH  = SYNC + STABLE - 1;

`ifdef PMOD_DEBOUNCE_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] pmod;
    logic [WIDTH-1:0] pmod_db;
    logic [WIDTH-1:0] pmod_rise;
    logic [WIDTH-1:0] pmod_fall;

    int total = 0;
    int bad   = 0;

    pmod_debounce #(
        .WIDTH        (WIDTH),
        .SYNC_STAGES  (SYNC),
        .STABLE_CYCLES(STABLE)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pmod     (pmod),
        .pmod_db  (pmod_db),
        .pmod_rise(pmod_rise),
        .pmod_fall(pmod_fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: a level is accepted once the last STABLE synchronised samples
    // all differ from the current output; hist[k] is the pin sampled k+1 edges ago.
    logic [WIDTH-1:0] hist [DEPTH];
    logic [WIDTH-1:0] mdb;
    logic [WIDTH-1:0] mrise;
    logic [WIDTH-1:0] mfall;

    function automatic logic [WIDTH-1:0] acceptMask();
        logic [WIDTH-1:0] m;
        m = '1;
        for (int b = 0; b < WIDTH; b++) begin
            for (int j = 0; j < STABLE; j++) begin
                if (hist[SYNC-1+j][b] == mdb[b]) m[b] = 1'b0;
            end
        end
        return m;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) hist[k] <= '0;
            mdb   <= '0;
            mrise <= '0;
            mfall <= '0;
        end else begin
            mdb   <= mdb ^ acceptMask();
            mrise <= EDGE ? (acceptMask() & ~mdb) : '0;
            mfall <= EDGE ? (acceptMask() & mdb) : '0;
            hist[0] <= pmod;
            for (int k = 1; k < DEPTH; k++) hist[k] <= hist[k-1];
        end
    end

    task automatic checkOutput(input string name, input logic [WIDTH-1:0] act,
                               input logic [WIDTH-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%b expected=%b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkCount(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        checkOutput("model_db", pmod_db, mdb);
        checkOutput("model_rise", pmod_rise, mrise);
        checkOutput("model_fall", pmod_fall, mfall);
    end

    // Event counters for the "exactly once" style checks.
    int rise0Cnt = 0;
    int fall0Cnt = 0;
    int rise1Cnt = 0;
    int fall1Cnt = 0;
    int high0Cnt = 0;
    always @(negedge clk) begin
        rise0Cnt <= rise0Cnt + int'(pmod_rise[0]);
        fall0Cnt <= fall0Cnt + int'(pmod_fall[0]);
        rise1Cnt <= rise1Cnt + int'(pmod_rise[1]);
        fall1Cnt <= fall1Cnt + int'(pmod_fall[1]);
        high0Cnt <= high0Cnt + int'(pmod_db[0]);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [WIDTH-1:0] p, input int cycles);
        pmod = p;
        tick(cycles);
    endtask

    initial begin
        int r0, f0, r1, f1, h0;
        int expN;
        logic [WIDTH-1:0] expBoth;
        logic [WIDTH-1:0] expBit0;
        expN    = EDGE ? 1 : 0;
        expBoth = EDGE ? 2'b11 : 2'b00;
        expBit0 = EDGE ? 2'b01 : 2'b00;

        // Pins high through reset.
        rst_n = 1'b0;
        pmod  = 2'b11;
        tick(3);
        checkOutput("rst_db", pmod_db, 2'b00);
        checkOutput("rst_rise", pmod_rise, 2'b00);
        rst_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick(1);
            checkOutput("rel_db_wait", pmod_db, 2'b00);
        end
        tick(1);
        checkOutput("rel_db_acc", pmod_db, 2'b11);
        checkOutput("rel_rise", pmod_rise, expBoth);
        tick(1);
        checkOutput("rel_rise_clr", pmod_rise, 2'b00);
        checkOutput("rel_db_hold", pmod_db, 2'b11);
        applyStimulus(2'b00, 12);
        checkOutput("clear_db", pmod_db, 2'b00);

        // Clean step on bit 0.
        r0 = rise0Cnt; r1 = rise1Cnt; f1 = fall1Cnt;
        pmod = 2'b01;
        tick(5);
        checkOutput("step_wait", pmod_db, 2'b00);
        tick(1);
        checkOutput("step_acc", pmod_db, 2'b01);
        checkOutput("step_rise", pmod_rise, expBit0);
        tick(6);
        checkCount("step_rise_cnt", rise0Cnt - r0, expN);
        checkCount("step_bit1_strobes", (rise1Cnt - r1) + (fall1Cnt - f1), 0);
        checkOutput("step_db_final", pmod_db, 2'b01);
        applyStimulus(2'b00, 12);

        // Three-cycle glitch is rejected.
        r0 = rise0Cnt; f0 = fall0Cnt; h0 = high0Cnt;
        applyStimulus(2'b01, 3);
        applyStimulus(2'b00, 10);
        checkOutput("glitch3_db", pmod_db, 2'b00);
        checkCount("glitch3_strobes", (rise0Cnt - r0) + (fall0Cnt - f0), 0);
        checkCount("glitch3_high", high0Cnt - h0, 0);

        // Four-cycle pulse is accepted, then released four cycles later.
        r0 = rise0Cnt; f0 = fall0Cnt; h0 = high0Cnt;
        applyStimulus(2'b01, 4);
        applyStimulus(2'b00, 12);
        checkOutput("glitch4_db", pmod_db, 2'b00);
        checkCount("glitch4_rise", rise0Cnt - r0, expN);
        checkCount("glitch4_fall", fall0Cnt - f0, expN);
        checkCount("glitch4_high", high0Cnt - h0, 4);

        // Bounce 1,0,1,1,0 then a steady 1.
        r0 = rise0Cnt;
        applyStimulus(2'b01, 1);
        applyStimulus(2'b00, 1);
        applyStimulus(2'b01, 1);
        applyStimulus(2'b01, 1);
        applyStimulus(2'b00, 1);
        checkOutput("bounce_mid", pmod_db, 2'b00);
        pmod = 2'b01;
        tick(5);
        checkOutput("bounce_wait", pmod_db, 2'b00);
        tick(1);
        checkOutput("bounce_acc", pmod_db, 2'b01);
        tick(4);
        checkCount("bounce_rise_cnt", rise0Cnt - r0, expN);
        applyStimulus(2'b00, 12);

        // Reset in the middle of a count.
        r0 = rise0Cnt;
        pmod = 2'b01;
        tick(4);
        rst_n = 1'b0;
        tick(1);
        checkOutput("midrst_db", pmod_db, 2'b00);
        checkOutput("midrst_rise", pmod_rise, 2'b00);
        tick(2);
        checkCount("midrst_no_strobe", rise0Cnt - r0, 0);
        rst_n = 1'b1;
        tick(5);
        checkOutput("midrst_wait", pmod_db, 2'b00);
        tick(1);
        checkOutput("midrst_acc", pmod_db, 2'b01);
        checkOutput("midrst_rise_acc", pmod_rise, expBit0);
        tick(3);
        checkCount("midrst_rise_cnt", rise0Cnt - r0, expN);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
